reg_sweeper: RTL
================

REG_SWEEPER -- requirements
Module: reg_sweeper

Interface
REQ-001 The block SHALL have parameter REG_W, default 5, register-number width.
REQ-002 The block SHALL have parameter BASE, default 8, first register number of every sweep (0 <= BASE < 2^REG_W).
REQ-003 The block SHALL have parameter LEN_W, default 4, width of the sweep-length input.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port go, input, 1 bit, arm request; its falling level launches a sweep.
REQ-007 The block SHALL have port direction, input, 1 bit, 1 = ascending, 0 = descending.
REQ-008 The block SHALL have port len, input, LEN_W bits, number of sweep steps.
REQ-009 The block SHALL have port stride, input, REG_W bits, register-number increment per step.
REQ-010 The block SHALL have port abort, input, 1 bit, terminates a running sweep.
REQ-011 The block SHALL have port regnum, output, REG_W bits, current register number.
REQ-012 The block SHALL have port wen, output, 1 bit, write enable, high on every sweep step.
REQ-013 The block SHALL have port busy, output, 1 bit, high in ARM or RUN.
REQ-014 The block SHALL have port done, output, 1 bit, high in DONE.

Function
REQ-015 The block SHALL implement exactly four states: IDLE, ARM, RUN, DONE, one-hot or encoded; all outputs are Moore, decoded from registered state only.
REQ-016 IDLE: go=1 -> ARM; else stay in IDLE.
REQ-017 ARM: go=1 -> stay in ARM; go=0 -> latch direction, len, stride into internal registers; then len=0 -> DONE, else RUN with step index k=1.
REQ-018 RUN: abort=1 -> DONE; else k==latched len -> DONE; else k <= k+1 and stay in RUN; go is ignored.
REQ-019 DONE: go=1 -> ARM; else stay in DONE.
REQ-020 In ARM, regnum SHALL equal BASE.
REQ-021 In RUN at step k, regnum SHALL equal (BASE + k*stride) mod 2^REG_W when ascending and (BASE - k*stride) mod 2^REG_W when descending; wrap-around is silent.
REQ-022 regnum SHALL be 0 in IDLE and DONE.
REQ-023 wen SHALL be 1 in RUN only; busy = ARM|RUN; done = DONE.
REQ-024 A non-aborted sweep SHALL hold RUN for exactly latched-len consecutive cycles; the maximum of 2^LEN_W-1 steps is supported and the step counter never overflows.
REQ-025 Changes to direction, len and stride after leaving ARM SHALL have no effect on the running sweep.
REQ-026 abort SHALL be ignored outside RUN; abort asserted on the cycle k==len still goes to DONE (same outcome).
REQ-027 stride=0 SHALL produce len steps all at regnum=BASE with wen=1.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE with regnum=0, wen=0, busy=0, done=0 on the following cycle, from any state including mid-sweep.
REQ-029 reset SHALL take priority over go and abort in the same cycle.
REQ-030 Latched direction, len, stride and k SHALL be cleared to 0 by reset.

Verification
REQ-031 The bench SHALL cover: reset; go=1 for 2 cycles then 0, direction=1, len=4, stride=1 -> regnum 8,8,9,10,11,12 then 0 with done=1; wen high exactly 4 cycles.
REQ-032 The bench SHALL cover: direction=0, len=4, stride=1 -> RUN regnum 7,6,5,4; then go=1 in DONE -> ARM, regnum=8, done=0.
REQ-033 The bench SHALL cover: direction=1, len=3, stride=12, REG_W=5 -> regnum 20,0,12 (wrap at 32); and direction=0, stride=3, len=3 -> 5,2,31.
REQ-034 The bench SHALL cover: len=0 -> ARM directly to DONE, wen never asserted; then abort=1 at k=2 of a len=6 sweep -> DONE next cycle, wen high exactly 2 cycles.
REQ-035 The bench SHALL cover: reset=1 at k=2 with go=1 and abort=1 -> next cycle IDLE, all outputs 0; toggling direction/len during RUN leaves the sequence unchanged.

Source files
------------

// File: rtl/reg_sweeper.sv
// Register-number sweeper: walks regnum from BASE by +/-stride for len steps.
// Latency: first step appears one cycle after go falls; outputs are Moore.
// No backpressure: a sweep runs to completion unless aborted or reset.
module reg_sweeper #(
  parameter int REG_W = 5,
  parameter int BASE  = 8,
  parameter int LEN_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             direction,
  input  logic [LEN_W-1:0] len,
  input  logic [REG_W-1:0] stride,
  input  logic             abort,
  output logic [REG_W-1:0] regnum,
  output logic             wen,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [REG_W-1:0] BASE_R = REG_W'(BASE);

  state_t           state;
  state_t           state_nxt;
  logic             dir_q;
  logic [LEN_W-1:0] len_q;
  logic [REG_W-1:0] stride_q;
  logic [LEN_W-1:0] k;
  // Running register number; kept as an accumulator so no multiplier is needed.
  logic [REG_W-1:0] pos;

  // Next-state decode; abort only matters while running.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = ARM;
      ARM: begin
        if (!go) state_nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        if (abort || (k == len_q)) state_nxt = DONE;
      end
      DONE: if (go) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus sweep datapath; parameters are captured as ARM is left.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      dir_q    <= 1'b0;
      len_q    <= '0;
      stride_q <= '0;
      k        <= '0;
      pos      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ARM: begin
          if (!go) begin
            dir_q    <= direction;
            len_q    <= len;
            stride_q <= stride;
            k        <= LEN_W'(1);
            pos      <= direction ? (BASE_R + stride) : (BASE_R - stride);
          end
        end
        RUN: begin
          // k never passes len_q, so it cannot overflow even at the maximum length.
          if (state_nxt == RUN) begin
            k   <= k + LEN_W'(1);
            pos <= dir_q ? (pos + stride_q) : (pos - stride_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    regnum = '0;
    if (state == ARM) regnum = BASE_R;
    else if (state == RUN) regnum = pos;
    wen  = (state == RUN);
    busy = (state == ARM) || (state == RUN);
    done = (state == DONE);
  end

endmodule
